// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse position tracker.
package mouse_pkg;

    // Packet assembly states: three byte slots plus a one-cycle commit state.
    typedef enum logic [1:0] {
        BYTE0  = 2'd0,
        BYTE1  = 2'd1,
        BYTE2  = 2'd2,
        UPDATE = 2'd3
    } mouse_state_t;

    // Bit positions inside the PS/2 header byte.
    localparam int HDR_L    = 0;
    localparam int HDR_R    = 1;
    localparam int HDR_SYNC = 3;
    localparam int HDR_XS   = 4;
    localparam int HDR_YS   = 5;
    localparam int HDR_XO   = 6;
    localparam int HDR_YO   = 7;

    // Signed working width for position arithmetic; wide enough that
    // a 12-bit position plus or minus a 9-bit delta never wraps.
    localparam int WORK_W = 14;

    // Header fields that matter after the sync bit has been checked.
    typedef struct packed {
        logic yo;
        logic xo;
        logic ys;
        logic xs;
        logic r;
        logic l;
    } mouse_hdr_t;

endpackage

// File: rtl/mouse_axis_clamp.sv
// Combinational single-axis update: pos +/- delta, clamped to 0..MAX_VAL.
module mouse_axis_clamp #(
    parameter int MAX_VAL = 1023
) (
    input  logic [11:0] pos,
    input  logic [8:0]  delta,
    input  logic        negate,
    output logic [11:0] pos_out
);
    import mouse_pkg::*;

    localparam logic signed [WORK_W-1:0] MAX_W = WORK_W'(MAX_VAL);

    logic signed [WORK_W-1:0] pos_ext;
    logic signed [WORK_W-1:0] delta_ext;
    logic signed [WORK_W-1:0] sum;

    assign pos_ext   = signed'({{(WORK_W-12){1'b0}}, pos});
    assign delta_ext = signed'({{(WORK_W-9){delta[8]}}, delta});

    // Apply the delta in the requested direction, then saturate at both ends.
    always_comb begin
        sum = negate ? (pos_ext - delta_ext) : (pos_ext + delta_ext);
        if (sum[WORK_W-1]) begin
            pos_out = 12'd0;
        end else if (sum > MAX_W) begin
            pos_out = MAX_W[11:0];
        end else begin
            pos_out = sum[11:0];
        end
    end

endmodule

// File: rtl/mouse_pos_tracker.sv
// Assembles 3-byte PS/2 mouse packets and keeps a clamped absolute cursor
// position plus button state, with an inter-byte timeout for resync.
module mouse_pos_tracker #(
    parameter int X_MAX       = 1023,
    parameter int Y_MAX       = 767,
    parameter int X_INIT      = 512,
    parameter int Y_INIT      = 384,
    parameter int TIMEOUT_CYC = 130000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [11:0] mouse_xpos,
    output logic [11:0] mouse_ypos,
    output logic        left,
    output logic        right,
    output logic        pos_valid,
    output logic        pkt_err
);
    import mouse_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    mouse_state_t     state_reg, state_next;
    mouse_hdr_t       hdr_reg;
    logic [7:0]       dx_reg, dy_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [11:0]      xpos_reg, ypos_reg;
    logic             left_reg, right_reg;
    logic             pos_valid_reg, pkt_err_reg;

    logic             hdr_load, dx_load, dy_load;
    logic             upd, err_next, timeout;
    logic [8:0]       dx9, dy9;
    logic [11:0]      x_new, y_new;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= BYTE0;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a byte arriving in UPDATE starts the next packet.
    always_comb begin
        state_next = state_reg;
        hdr_load   = 1'b0;
        dx_load    = 1'b0;
        dy_load    = 1'b0;
        upd        = 1'b0;
        err_next   = 1'b0;
        timeout    = 1'b0;
        case (state_reg)
            BYTE0, UPDATE: begin
                upd        = (state_reg == UPDATE);
                state_next = BYTE0;
                if (rx_valid) begin
                    if (rx_data[HDR_SYNC]) begin
                        hdr_load   = 1'b1;
                        state_next = BYTE1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            BYTE1: begin
                if (rx_valid) begin
                    dx_load    = 1'b1;
                    state_next = BYTE2;
                end else if (cnt_reg == CNT_LAST) begin
                    timeout    = 1'b1;
                    err_next   = 1'b1;
                    state_next = BYTE0;
                end
            end
            BYTE2: begin
                if (rx_valid) begin
                    dy_load    = 1'b1;
                    state_next = UPDATE;
                end else if (cnt_reg == CNT_LAST) begin
                    timeout    = 1'b1;
                    err_next   = 1'b1;
                    state_next = BYTE0;
                end
            end
            default: state_next = BYTE0;
        endcase
    end

    // Idle counter: runs only while waiting for bytes 2 and 3 of a packet.
    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        if (rx_valid || timeout || !(state_reg == BYTE1 || state_reg == BYTE2)) begin
            cnt_next = '0;
        end
    end

    // Timeout counter and packet byte storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            hdr_reg <= '0;
            dx_reg  <= '0;
            dy_reg  <= '0;
        end else begin
            cnt_reg <= cnt_next;
            if (hdr_load) begin
                hdr_reg.l  <= rx_data[HDR_L];
                hdr_reg.r  <= rx_data[HDR_R];
                hdr_reg.xs <= rx_data[HDR_XS];
                hdr_reg.ys <= rx_data[HDR_YS];
                hdr_reg.xo <= rx_data[HDR_XO];
                hdr_reg.yo <= rx_data[HDR_YO];
            end
            if (dx_load) dx_reg <= rx_data;
            if (dy_load) dy_reg <= rx_data;
        end
    end

    // An overflowed axis contributes no movement.
    assign dx9 = hdr_reg.xo ? 9'd0 : {hdr_reg.xs, dx_reg};
    assign dy9 = hdr_reg.yo ? 9'd0 : {hdr_reg.ys, dy_reg};

    mouse_axis_clamp #(.MAX_VAL(X_MAX)) u_x_clamp (
        .pos     (xpos_reg),
        .delta   (dx9),
        .negate  (1'b0),
        .pos_out (x_new)
    );

    // PS/2 Y grows upward while screen rows grow downward.
    mouse_axis_clamp #(.MAX_VAL(Y_MAX)) u_y_clamp (
        .pos     (ypos_reg),
        .delta   (dy9),
        .negate  (1'b1),
        .pos_out (y_new)
    );

    // Output registers: commit position and buttons in UPDATE, pulse flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xpos_reg      <= 12'(X_INIT);
            ypos_reg      <= 12'(Y_INIT);
            left_reg      <= 1'b0;
            right_reg     <= 1'b0;
            pos_valid_reg <= 1'b0;
            pkt_err_reg   <= 1'b0;
        end else begin
            pos_valid_reg <= upd;
            pkt_err_reg   <= err_next;
            if (upd) begin
                xpos_reg  <= x_new;
                ypos_reg  <= y_new;
                left_reg  <= hdr_reg.l;
                right_reg <= hdr_reg.r;
            end
        end
    end

    assign mouse_xpos = xpos_reg;
    assign mouse_ypos = ypos_reg;
    assign left       = left_reg;
    assign right      = right_reg;
    assign pos_valid  = pos_valid_reg;
    assign pkt_err    = pkt_err_reg;

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Testbench for mouse_pos_tracker: directed packets, a packet-level model
// checked every cycle, and literal expectations after each scenario.
module tb_mouse_pos_tracker;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [11:0] mouse_xpos, mouse_ypos;
    logic        left, right, pos_valid, pkt_err;

    always #5 clk = ~clk;

    mouse_pos_tracker #(
        .X_MAX(1023), .Y_MAX(767), .X_INIT(512), .Y_INIT(384), .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .left       (left),
        .right      (right),
        .pos_valid  (pos_valid),
        .pkt_err    (pkt_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int pv_count = 0;
    int err_count = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (packet level) ----------------
    int         m_x, m_y;
    bit         m_l, m_r, m_pv, m_err;
    int         nb, idle;
    bit         upd_pend;
    logic [7:0] pk [3];

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int delta9(input bit ovf, input bit sgn, input logic [7:0] b);
        if (ovf) return 0;
        return sgn ? int'(b) - 256 : int'(b);
    endfunction

    // Model: a completed packet takes effect one cycle later, visible the next.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_x = 512; m_y = 384; m_l = 0; m_r = 0; m_pv = 0; m_err = 0;
            nb = 0; idle = 0; upd_pend = 0;
        end else begin
            m_pv  = 0;
            m_err = 0;
            if (upd_pend) begin
                m_x = clampi(m_x + delta9(pk[0][6], pk[0][4], pk[1]), 1023);
                m_y = clampi(m_y - delta9(pk[0][7], pk[0][5], pk[2]), 767);
                m_l = pk[0][0];
                m_r = pk[0][1];
                m_pv = 1;
                upd_pend = 0;
            end
            if (rx_valid) begin
                idle = 0;
                if (nb == 0) begin
                    if (rx_data[3]) begin pk[0] = rx_data; nb = 1; end
                    else m_err = 1;
                end else if (nb == 1) begin
                    pk[1] = rx_data; nb = 2;
                end else begin
                    pk[2] = rx_data; nb = 0; upd_pend = 1;
                end
            end else if (nb > 0) begin
                idle++;
                if (idle == TO) begin
                    nb = 0; idle = 0; m_err = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("xpos",      int'(mouse_xpos), m_x);
            chk("ypos",      int'(mouse_ypos), m_y);
            chk("left",      int'(left),       int'(m_l));
            chk("right",     int'(right),      int'(m_r));
            chk("pos_valid", int'(pos_valid),  int'(m_pv));
            chk("pkt_err",   int'(pkt_err),    int'(m_err));
            if (pos_valid) pv_count++;
            if (pkt_err)   err_count++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a);
        send_byte(b);
        send_byte(c);
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset, no traffic.
        idle_cyc(10);
        chk("lit_reset_x", int'(mouse_xpos), 512);
        chk("lit_reset_y", int'(mouse_ypos), 384);
        chk("lit_no_pv",   pv_count, 0);

        // Basic packet.
        pkt(8'h08, 8'h0A, 8'h05);
        idle_cyc(4);
        chk("lit_p1_x", int'(mouse_xpos), 522);
        chk("lit_p1_y", int'(mouse_ypos), 379);
        chk("lit_p1_model_x", m_x, 522);
        chk("lit_p1_lr", int'({left, right}), 0);
        chk("lit_p1_pv", pv_count, 1);

        // dx = -256 three times back to back: clamp at 0.
        repeat (3) pkt(8'h19, 8'h00, 8'h00);
        idle_cyc(4);
        chk("lit_xmin_x", int'(mouse_xpos), 0);
        chk("lit_xmin_left", int'(left), 1);
        chk("lit_xmin_pv", pv_count, 4);

        // dy = -128 four times: clamp at Y_MAX.
        repeat (4) pkt(8'h28, 8'h00, 8'h80);
        idle_cyc(4);
        chk("lit_ymax_y", int'(mouse_ypos), 767);
        chk("lit_ymax_model_y", m_y, 767);
        chk("lit_ymax_left", int'(left), 0);

        // Bad sync byte, then a good packet.
        send_byte(8'h02);
        pkt(8'h08, 8'h01, 8'h00);
        idle_cyc(4);
        chk("lit_resync_x", int'(mouse_xpos), 1);
        chk("lit_resync_err", err_count, 1);

        // Timeout drops a partial packet.
        send_byte(8'h08);
        send_byte(8'h05);
        idle_cyc(TO);
        pkt(8'h08, 8'h02, 8'h00);
        idle_cyc(4);
        chk("lit_timeout_x", int'(mouse_xpos), 3);
        chk("lit_timeout_y", int'(mouse_ypos), 767);
        chk("lit_timeout_err", err_count, 2);

        // Byte arriving one cycle before expiry still counts.
        send_byte(8'h08);
        idle_cyc(TO - 1);
        send_byte(8'h02);
        send_byte(8'h00);
        idle_cyc(4);
        chk("lit_bytewins_x", int'(mouse_xpos), 5);
        chk("lit_bytewins_err", err_count, 2);

        // X overflow: x unchanged, y still applied.
        pkt(8'h48, 8'hFF, 8'h03);
        idle_cyc(4);
        chk("lit_xovf_x", int'(mouse_xpos), 5);
        chk("lit_xovf_y", int'(mouse_ypos), 764);

        // Right button.
        pkt(8'h0A, 8'h00, 8'h00);
        idle_cyc(4);
        chk("lit_right", int'(right), 1);
        chk("lit_right_left", int'(left), 0);

        // dx = +255 five times: clamp at X_MAX.
        repeat (5) pkt(8'h08, 8'hFF, 8'h00);
        idle_cyc(4);
        chk("lit_xmax_x", int'(mouse_xpos), 1023);

        // Reset mid-packet abandons it.
        send_byte(8'h08);
        send_byte(8'h05);
        rst = 1'b1;
        idle_cyc(2);
        rst = 1'b0;
        chk("lit_midrst_x", int'(mouse_xpos), 512);
        chk("lit_midrst_y", int'(mouse_ypos), 384);
        chk("lit_midrst_lr", int'({left, right}), 0);
        pkt(8'h08, 8'h01, 8'h01);
        idle_cyc(4);
        chk("lit_after_rst_x", int'(mouse_xpos), 513);
        chk("lit_after_rst_y", int'(mouse_ypos), 383);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
